// File: rtl/foc_pkg.sv
// Shared types and constants for the FOC drive sequencer: FSM state encoding
// and coefficient table geometry.
package foc_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CFG   = 3'd1,
      ARMED = 3'd2,
      HOLD  = 3'd3,
      WAIT  = 3'd4
   } foc_state_e;

   localparam int NUM_COEF = 4;

   localparam int KP = 0;
   localparam int KI = 1;
   localparam int KD = 2;
   localparam int K3 = 3;

endpackage

// File: rtl/foc_sat_neg_sum.sv
// Third phase current from the other two: y = -(a + b), saturated to the
// signed range of W bits.
module foc_sat_neg_sum #(
   parameter int W = 19
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   localparam logic signed [W+1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [W+1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

   logic signed [W+1:0] neg_sum;

   always_comb begin
      // Two guard bits cover both the sum overflow and the negation of -2^W.
      neg_sum = -($signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}));
      if (neg_sum > MAX_V) begin
         y = MAX_V[W-1:0];
      end else if (neg_sum < MIN_V) begin
         y = MIN_V[W-1:0];
      end else begin
         y = neg_sum[W-1:0];
      end
   end

endmodule

// File: rtl/foc_drive_sequencer.sv
// Sequences PID coefficient downloads and sample launches toward a FOC
// current controller, with a one-deep latest-wins sample slot.
module foc_drive_sequencer
   import foc_pkg::*;
#(
   parameter int D_WIDTH    = 19,
   parameter int Q_BITS     = 15,
   parameter int VALID_HOLD = 4,
   parameter int TIMEOUT    = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               host_wr_en,
   input  logic               host_wr_axis,
   input  logic [1:0]         host_wr_addr,
   input  logic [D_WIDTH-1:0] host_wr_data,
   input  logic               cfg_start,
   input  logic               samp_valid,
   input  logic [D_WIDTH-1:0] samp_angle,
   input  logic [D_WIDTH-1:0] samp_currA,
   input  logic [D_WIDTH-1:0] samp_currB,
   input  logic [D_WIDTH-1:0] currT,
   input  logic               ready,
   output logic [D_WIDTH-1:0] angle_out,
   output logic [D_WIDTH-1:0] currA_out,
   output logic [D_WIDTH-1:0] currB_out,
   output logic [D_WIDTH-1:0] currC_out,
   output logic [D_WIDTH-1:0] currT_out,
   output logic               valid_out,
   output logic               pid_d_wen,
   output logic               pid_q_wen,
   output logic [D_WIDTH-1:0] pid_d_addr,
   output logic [D_WIDTH-1:0] pid_q_addr,
   output logic [D_WIDTH-1:0] pid_d_data,
   output logic [D_WIDTH-1:0] pid_q_data,
   output logic               busy,
   output logic               timeout_err,
   output logic [7:0]         drop_cnt,
   output logic [2:0]         state_dbg
);

   localparam int CNT_MAX_A = (TIMEOUT > VALID_HOLD) ? TIMEOUT : VALID_HOLD;
   localparam int CNT_MAX   = (CNT_MAX_A > NUM_COEF) ? CNT_MAX_A : NUM_COEF;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CFG_LAST  = CNT_W'(NUM_COEF - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(VALID_HOLD - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   if (Q_BITS < 0 || Q_BITS >= D_WIDTH) begin : g_bad_q_bits
      $error("Q_BITS must lie below D_WIDTH");
   end

   foc_state_e state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [D_WIDTH-1:0] shd_d_q [NUM_COEF];
   logic [D_WIDTH-1:0] shd_d_d [NUM_COEF];
   logic [D_WIDTH-1:0] shd_q_q [NUM_COEF];
   logic [D_WIDTH-1:0] shd_q_d [NUM_COEF];
   logic [D_WIDTH-1:0] dl_d_q [NUM_COEF];
   logic [D_WIDTH-1:0] dl_d_d [NUM_COEF];
   logic [D_WIDTH-1:0] dl_q_q [NUM_COEF];
   logic [D_WIDTH-1:0] dl_q_d [NUM_COEF];
   logic [D_WIDTH-1:0] ang_q, ang_d, ca_q, ca_d, cb_q, cb_d, cc_q, cc_d, ct_q, ct_d;
   logic [D_WIDTH-1:0] pend_ang_q, pend_ang_d, pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic               pend_full_q, pend_full_d;
   logic               cfg_pend_q, cfg_pend_d;
   logic [7:0]         drop_q, drop_d;
   logic               terr_q, terr_d;
   logic               ready_q, ready_d;

   logic               enter_cfg, launch, use_pend, to_slot, ready_rise;
   logic [D_WIDTH-1:0] l_ang, l_a, l_b, l_c;

   assign use_pend = (state_q == ARMED) && !cfg_start && !cfg_pend_q && pend_full_q;
   assign l_ang    = use_pend ? pend_ang_q : samp_angle;
   assign l_a      = use_pend ? pend_a_q   : samp_currA;
   assign l_b      = use_pend ? pend_b_q   : samp_currB;

   foc_sat_neg_sum #(.W(D_WIDTH)) u_sat_neg_sum (
      .a (l_a),
      .b (l_b),
      .y (l_c)
   );

   assign ready_rise = ready && !ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shd_d_d     = shd_d_q;
      shd_q_d     = shd_q_q;
      dl_d_d      = dl_d_q;
      dl_q_d      = dl_q_q;
      ang_d       = ang_q;
      ca_d        = ca_q;
      cb_d        = cb_q;
      cc_d        = cc_q;
      ct_d        = ct_q;
      pend_ang_d  = pend_ang_q;
      pend_a_d    = pend_a_q;
      pend_b_d    = pend_b_q;
      pend_full_d = pend_full_q;
      cfg_pend_d  = cfg_pend_q;
      drop_d      = drop_q;
      terr_d      = terr_q;
      ready_d     = ready;
      enter_cfg   = 1'b0;
      launch      = 1'b0;
      to_slot     = 1'b0;

      if (host_wr_en) begin
         if (host_wr_axis) shd_q_d[host_wr_addr] = host_wr_data;
         else              shd_d_d[host_wr_addr] = host_wr_data;
      end

      case (state_q)
         IDLE: begin
            if (cfg_start) enter_cfg = 1'b1;
         end
         CFG: begin
            if (cnt_q == CFG_LAST) begin
               state_d = ARMED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ARMED: begin
            if (cfg_start || cfg_pend_q) begin
               enter_cfg = 1'b1;
               to_slot   = samp_valid;
            end else if (pend_full_q) begin
               launch      = 1'b1;
               pend_full_d = 1'b0;
               to_slot     = samp_valid;
            end else if (samp_valid) begin
               launch = 1'b1;
            end
         end
         HOLD: begin
            to_slot = samp_valid;
            if (cfg_start) cfg_pend_d = 1'b1;
            if (cnt_q == HOLD_LAST) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT: begin
            to_slot = samp_valid;
            if (cfg_start) cfg_pend_d = 1'b1;
            if (ready_rise) begin
               if (cfg_pend_q || cfg_start) begin
                  enter_cfg = 1'b1;
               end else begin
                  state_d = ARMED;
                  cnt_d   = '0;
               end
            end else if (cnt_q == WAIT_LAST) begin
               terr_d  = 1'b1;
               state_d = ARMED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // The download copy is taken before this cycle's host write lands.
      if (enter_cfg) begin
         state_d    = CFG;
         cnt_d      = '0;
         cfg_pend_d = 1'b0;
         dl_d_d     = shd_d_q;
         dl_q_d     = shd_q_q;
      end

      if (launch) begin
         state_d = HOLD;
         cnt_d   = '0;
         ang_d   = l_ang;
         ca_d    = l_a;
         cb_d    = l_b;
         cc_d    = l_c;
         ct_d    = currT;
      end

      if (to_slot) begin
         if (pend_full_q && !use_pend && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
         pend_ang_d  = samp_angle;
         pend_a_d    = samp_currA;
         pend_b_d    = samp_currB;
         pend_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shd_d_q     <= '{default: '0};
         shd_q_q     <= '{default: '0};
         dl_d_q      <= '{default: '0};
         dl_q_q      <= '{default: '0};
         ang_q       <= '0;
         ca_q        <= '0;
         cb_q        <= '0;
         cc_q        <= '0;
         ct_q        <= '0;
         pend_ang_q  <= '0;
         pend_a_q    <= '0;
         pend_b_q    <= '0;
         pend_full_q <= 1'b0;
         cfg_pend_q  <= 1'b0;
         drop_q      <= '0;
         terr_q      <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shd_d_q     <= shd_d_d;
         shd_q_q     <= shd_q_d;
         dl_d_q      <= dl_d_d;
         dl_q_q      <= dl_q_d;
         ang_q       <= ang_d;
         ca_q        <= ca_d;
         cb_q        <= cb_d;
         cc_q        <= cc_d;
         ct_q        <= ct_d;
         pend_ang_q  <= pend_ang_d;
         pend_a_q    <= pend_a_d;
         pend_b_q    <= pend_b_d;
         pend_full_q <= pend_full_d;
         cfg_pend_q  <= cfg_pend_d;
         drop_q      <= drop_d;
         terr_q      <= terr_d;
         ready_q     <= ready_d;
      end
   end

   // Handshake: valid_out is high for exactly VALID_HOLD cycles per sample;
   // the controller then signals completion with a low-to-high edge on ready.
   assign valid_out = (state_q == HOLD);
   assign busy      = !(state_q == IDLE || state_q == ARMED);

   always_comb begin
      pid_d_wen  = 1'b1;
      pid_q_wen  = 1'b1;
      pid_d_addr = '0;
      pid_q_addr = '0;
      pid_d_data = '0;
      pid_q_data = '0;
      if (state_q == CFG) begin
         pid_d_wen  = 1'b0;
         pid_q_wen  = 1'b0;
         pid_d_addr = {{(D_WIDTH-2){1'b0}}, cnt_q[1:0]};
         pid_q_addr = {{(D_WIDTH-2){1'b0}}, cnt_q[1:0]};
         pid_d_data = dl_d_q[cnt_q[1:0]];
         pid_q_data = dl_q_q[cnt_q[1:0]];
      end
   end

   assign angle_out   = ang_q;
   assign currA_out   = ca_q;
   assign currB_out   = cb_q;
   assign currC_out   = cc_q;
   assign currT_out   = ct_q;
   assign timeout_err = terr_q;
   assign drop_cnt    = drop_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_foc_drive_sequencer.sv
// Scoreboard bench for foc_drive_sequencer: randomized samples and coefficient
// tables checked against a behavioural model of launches and downloads.
`timescale 1ns/1ps
module tb_foc_drive_sequencer;
   import foc_pkg::*;

   localparam int W    = 19;
   localparam int VH   = 4;
   localparam int TO   = 16;
   localparam int SMAX = (1 << (W-1)) - 1;
   localparam int SMIN = -(1 << (W-1));

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         host_wr_en = 1'b0, host_wr_axis = 1'b0;
   logic [1:0]   host_wr_addr = '0;
   logic [W-1:0] host_wr_data = '0;
   logic         cfg_start = 1'b0, samp_valid = 1'b0, ready = 1'b0;
   logic [W-1:0] samp_angle = '0, samp_currA = '0, samp_currB = '0, currT = '0;
   logic [W-1:0] angle_out, currA_out, currB_out, currC_out, currT_out;
   logic         valid_out, pid_d_wen, pid_q_wen, busy, timeout_err;
   logic [W-1:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data;
   logic [7:0]   drop_cnt;
   logic [2:0]   state_dbg;

   foc_drive_sequencer #(.D_WIDTH(W), .Q_BITS(15), .VALID_HOLD(VH), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .host_wr_en(host_wr_en), .host_wr_axis(host_wr_axis),
      .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .cfg_start(cfg_start), .samp_valid(samp_valid),
      .samp_angle(samp_angle), .samp_currA(samp_currA), .samp_currB(samp_currB),
      .currT(currT), .ready(ready),
      .angle_out(angle_out), .currA_out(currA_out), .currB_out(currB_out),
      .currC_out(currC_out), .currT_out(currT_out), .valid_out(valid_out),
      .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
      .pid_d_addr(pid_d_addr), .pid_q_addr(pid_q_addr),
      .pid_d_data(pid_d_data), .pid_q_data(pid_q_data),
      .busy(busy), .timeout_err(timeout_err), .drop_cnt(drop_cnt),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [5*W-1:0] exp_samp_q[$];
   logic [3*W-1:0] exp_wr_q[$];
   logic [W-1:0]   shd_m [2][4];
   int             drop_m = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   function automatic logic [W-1:0] sat_neg(input logic [W-1:0] a, input logic [W-1:0] b);
      int s;
      s = -(int'($signed(a)) + int'($signed(b)));
      if (s > SMAX) s = SMAX;
      if (s < SMIN) s = SMIN;
      return s[W-1:0];
   endfunction

   // ---------------- monitor ----------------
   initial begin : monitor
      logic           pv;
      int             run;
      logic [5*W-1:0] es;
      logic [3*W-1:0] ew;
      pv  = 1'b0;
      run = 0;
      forever begin
         @(negedge clk);
         if (valid_out && !pv) begin
            if (exp_samp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_launch: got angle %0h, required no launch", angle_out);
            end else begin
               es = exp_samp_q.pop_front();
               check("launch_sample", {angle_out, currA_out, currB_out, currC_out, currT_out}, es);
            end
            run = 0;
         end
         if (valid_out) run++;
         if (!valid_out && pv) check("valid_len", run, VH);
         pv = valid_out;
         if (!pid_d_wen || !pid_q_wen) begin
            if (exp_wr_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_write: got addr %0h, required no write", pid_d_addr);
            end else begin
               ew = exp_wr_q.pop_front();
               check("coef_write", {pid_d_addr, pid_d_data, pid_q_data}, ew);
               check("coef_pair", {pid_d_wen, pid_q_wen, pid_q_addr}, {2'b00, ew[3*W-1:2*W]});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_state(input foc_state_e s, input int budget, input string name);
      int i;
      i = 0;
      while (state_dbg != s && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(name, state_dbg, s);
   endtask

   task automatic host_write(input logic axis, input logic [1:0] addr, input logic [W-1:0] data);
      host_wr_en = 1'b1; host_wr_axis = axis; host_wr_addr = addr; host_wr_data = data;
      @(negedge clk);
      host_wr_en = 1'b0;
      shd_m[axis][addr] = data;
   endtask

   task automatic push_cfg(input int n);
      for (int k = 0; k < n; k++) exp_wr_q.push_back({W'(k), shd_m[0][k], shd_m[1][k]});
   endtask

   task automatic pulse_cfg();
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   task automatic drive_sample(input logic [W-1:0] ang, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] t);
      samp_valid = 1'b1; samp_angle = ang; samp_currA = a; samp_currB = b; currT = t;
      @(negedge clk);
      samp_valid = 1'b0;
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] ang, t;
      ang = W'($urandom);
      t   = W'($urandom);
      wait_state(ARMED, 40, "reach_armed");
      exp_samp_q.push_back({ang, a, b, sat_neg(a, b), t});
      drive_sample(ang, a, b, t);
      wait_state(WAIT, 20, "reach_wait");
      pulse_ready();
      check("ready_to_armed", state_dbg, ARMED);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [W-1:0] ang, a, b, t;
      int n;
      for (int x = 0; x < 2; x++) for (int k = 0; k < 4; k++) shd_m[x][k] = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_state", state_dbg, IDLE);
      check("rst_ctrl", {valid_out, pid_d_wen, pid_q_wen, busy, timeout_err, drop_cnt}, {5'b01100, 8'd0});
      check("rst_pid_bus", {pid_d_addr, pid_q_addr, pid_d_data, pid_q_data}, '0);
      check("rst_samples", {angle_out, currA_out, currB_out, currC_out, currT_out}, '0);
      rst = 1'b0;
      @(negedge clk);

      // samples are ignored while idle
      drive_sample(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      @(negedge clk);
      check("idle_ignores_samp", {state_dbg, busy}, {IDLE, 1'b0});

      // first download: {4096, 512, 0, 0} on both axes
      host_write(1'b0, 2'd0, W'(4096)); host_write(1'b0, 2'd1, W'(512));
      host_write(1'b1, 2'd0, W'(4096)); host_write(1'b1, 2'd1, W'(512));
      push_cfg(4);
      pulse_cfg();
      check("cfg_busy", {state_dbg, busy}, {CFG, 1'b1});
      wait_state(ARMED, 10, "cfg_to_armed");
      check("armed_idle_bus", {pid_d_wen, pid_q_wen, busy, 8'(exp_wr_q.size())}, {3'b110, 8'd0});

      // launches: cancellation, saturation both ways, random
      launch(W'(16384), W'(-16384));
      launch(W'(SMIN), W'(SMIN));
      launch(W'(SMAX), W'(SMAX));
      launch(W'(SMAX), W'(0));
      for (int i = 0; i < 6; i++) launch(W'($urandom), W'($urandom));

      // host write during download only affects the next download
      for (int k = 0; k < 4; k++) begin
         host_write(1'b0, 2'(k), W'($urandom));
         host_write(1'b1, 2'(k), W'($urandom));
      end
      wait_state(ARMED, 10, "pre_cfg2_armed");
      push_cfg(4);
      pulse_cfg();
      host_write(1'b0, 2'd2, W'($urandom));
      host_write(1'b1, 2'd1, W'($urandom));
      wait_state(ARMED, 10, "cfg2_to_armed");
      push_cfg(4);
      pulse_cfg();
      wait_state(ARMED, 10, "cfg3_to_armed");
      check("cfg3_drained", exp_wr_q.size(), 0);

      // three samples during WAIT: two drops, latest launches right after ARMED
      launch(W'($urandom), W'($urandom));
      ang = W'($urandom); a = W'($urandom); b = W'($urandom); t = W'($urandom);
      exp_samp_q.push_back({ang, a, b, sat_neg(a, b), t});
      drive_sample(ang, a, b, t);
      wait_state(WAIT, 20, "drop_wait");
      for (int i = 0; i < 3; i++) begin
         ang = W'($urandom); a = W'($urandom); b = W'($urandom); t = W'($urandom);
         if (i == 2) exp_samp_q.push_back({ang, a, b, sat_neg(a, b), t});
         drive_sample(ang, a, b, t);
         @(negedge clk);
      end
      drop_m = 2;
      check("drop_cnt_3", drop_cnt, drop_m);
      pulse_ready();
      check("drop_ready_armed", state_dbg, ARMED);
      @(negedge clk);
      check("pending_launch_next", valid_out, 1'b1);
      wait_state(WAIT, 20, "drop_wait2");
      pulse_ready();

      // bursts of samples during WAIT drive drop_cnt into saturation
      wait_state(ARMED, 10, "burst_armed");
      ang = W'($urandom); a = W'($urandom); b = W'($urandom); t = W'($urandom);
      exp_samp_q.push_back({ang, a, b, sat_neg(a, b), t});
      drive_sample(ang, a, b, t);
      for (int r = 0; r < 24; r++) begin
         wait_state(WAIT, 20, "burst_wait");
         samp_valid = 1'b1;
         for (int i = 0; i < 12; i++) begin
            samp_angle = W'($urandom); samp_currA = W'($urandom);
            samp_currB = W'($urandom); currT = W'($urandom);
            @(negedge clk);
         end
         samp_valid = 1'b0;
         exp_samp_q.push_back({samp_angle, samp_currA, samp_currB,
                               sat_neg(samp_currA, samp_currB), currT});
         drop_m = (drop_m + 11 > 255) ? 255 : drop_m + 11;
         check("drop_cnt_burst", drop_cnt, drop_m);
         pulse_ready();
      end
      wait_state(WAIT, 20, "burst_last_wait");
      pulse_ready();

      // ready held low: timeout after TO cycles of WAIT
      launch(W'($urandom), W'($urandom));
      ang = W'($urandom); a = W'($urandom); b = W'($urandom); t = W'($urandom);
      exp_samp_q.push_back({ang, a, b, sat_neg(a, b), t});
      drive_sample(ang, a, b, t);
      wait_state(WAIT, 20, "to_wait");
      check("to_err_before", timeout_err, 1'b0);
      n = 0;
      while (state_dbg == WAIT && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("to_wait_cycles", n, TO);
      check("to_after", {state_dbg, timeout_err}, {ARMED, 1'b1});

      // config request during HOLD is served at the next ready edge
      ang = W'($urandom); a = W'($urandom); b = W'($urandom); t = W'($urandom);
      exp_samp_q.push_back({ang, a, b, sat_neg(a, b), t});
      drive_sample(ang, a, b, t);
      pulse_cfg();
      wait_state(WAIT, 20, "cfgpend_wait");
      push_cfg(4);
      pulse_ready();
      check("cfgpend_to_cfg", state_dbg, CFG);
      wait_state(ARMED, 10, "cfgpend_armed");
      check("to_err_sticky", timeout_err, 1'b1);

      // config and sample together in ARMED: config first, sample afterwards
      ang = W'($urandom); a = W'($urandom); b = W'($urandom); t = W'($urandom);
      push_cfg(4);
      exp_samp_q.push_back({ang, a, b, sat_neg(a, b), t});
      cfg_start = 1'b1;
      drive_sample(ang, a, b, t);
      cfg_start = 1'b0;
      check("cfg_wins", state_dbg, CFG);
      wait_state(WAIT, 30, "cfg_samp_wait");
      pulse_ready();
      wait_state(ARMED, 10, "pre_reset_armed");
      check("queues_before_reset", {16'(exp_samp_q.size()), 16'(exp_wr_q.size())}, 32'd0);

      // reset during download: only k=0,1 complete
      push_cfg(2);
      pulse_cfg();
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_cfg", {state_dbg, pid_d_wen, pid_q_wen, busy}, {IDLE, 3'b110});
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int x = 0; x < 2; x++) for (int k = 0; k < 4; k++) shd_m[x][k] = '0;
      drop_m = 0;
      check("rst_status_clear", {timeout_err, drop_cnt, 8'(exp_wr_q.size())}, 17'd0);
      push_cfg(4);
      pulse_cfg();
      wait_state(ARMED, 10, "post_rst_cfg");

      repeat (4) @(negedge clk);
      check("final_queues", {16'(exp_samp_q.size()), 16'(exp_wr_q.size())}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/foc_drive_sequencer.md
FOC_DRIVE_SEQUENCER -- requirements
Module: foc_drive_sequencer

Interface
REQ-001 Parameter D_WIDTH, default 19: sample, coefficient and address width.
REQ-002 Parameter Q_BITS, default 15: fractional bits of all current values.
REQ-003 Parameter VALID_HOLD, default 4: number of cycles valid_out stays high per sample.
REQ-004 Parameter TIMEOUT, default 4096: maximum cycles to wait for a ready rising edge.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 host_wr_en, host_wr_axis, host_wr_addr, host_wr_data  in  1/1/2/D_WIDTH  write into the shadow coefficient table (axis 0 = d, axis 1 = q).
REQ-009 cfg_start  in  1  one-cycle pulse; requests download of the shadow table to the controller.
REQ-010 samp_valid, samp_angle, samp_currA, samp_currB  in  1/D_WIDTH x3  sample strobe and sample data from ADC/resolver.
REQ-011 currT  in  D_WIDTH signed  target current; registered into currT_out with each launched sample.
REQ-012 ready  in  1  controller done indication.
REQ-013 angle_out, currA_out, currB_out, currC_out, currT_out  out  D_WIDTH each  held sample presented to the controller.
REQ-014 valid_out  out  1  sample launch strobe.
REQ-015 pid_d_wen, pid_q_wen  out  1  active-low coefficient write enables.
REQ-016 pid_d_addr, pid_q_addr, pid_d_data, pid_q_data  out  D_WIDTH each  coefficient write address and data.
REQ-017 busy, timeout_err, drop_cnt  out  1/1/8  status outputs.

Function
REQ-018 The FSM SHALL have states IDLE, CFG, ARMED, HOLD and WAIT.
REQ-019 IDLE: on cfg_start go to CFG; samp_valid is ignored.
REQ-020 CFG: each cycle k = 0..3 SHALL drive pid_*_wen=0, pid_*_addr=k, and pid_d_data/pid_q_data from shadow[d][k]/shadow[q][k]; the next cycle drives wen=1 and goes to ARMED (4 write cycles total).
REQ-021 ARMED: on samp_valid, capture the sample in the same edge: angle, A, B, currC_out = -(A+B) saturated to D_WIDTH signed, currT; then go to HOLD with valid_out=1.
REQ-022 HOLD: valid_out SHALL stay 1 for exactly VALID_HOLD cycles, then drop to 0 and go to WAIT.
REQ-023 WAIT: detect a ready rising edge using a registered copy of ready; on the edge go to ARMED, or to CFG if a config request is pending.
REQ-024 WAIT timeout: if no rising edge within TIMEOUT cycles, set timeout_err (sticky) and go to ARMED.
REQ-025 A samp_valid in HOLD/WAIT SHALL overwrite a single pending slot (latest wins) and increment drop_cnt if the slot was already full; drop_cnt saturates at 255.
REQ-026 On entering ARMED with the pending slot full, the pending sample SHALL launch on the next cycle without waiting for samp_valid.
REQ-027 cfg_start in HOLD/WAIT SHALL set a pending-config flag; cfg_start in CFG SHALL be ignored.
REQ-028 cfg_start and samp_valid together in ARMED: config wins and the sample goes to the pending slot.
REQ-029 A host write during CFG SHALL take effect in the shadow table, but the download in progress SHALL use the values latched at CFG entry.
REQ-030 busy SHALL be 1 in every state except IDLE and ARMED.
REQ-031 Shadow table writes are accepted in every state.

Reset
REQ-032 While rst=1: state=IDLE, valid_out=0, pid_*_wen=1, all addr/data/sample outputs=0, busy=0, timeout_err=0, drop_cnt=0, pending flags cleared, shadow table=0.
REQ-033 rst asserted mid-HOLD or mid-CFG SHALL abort immediately to the reset values; no partial write cycle SHALL complete after reset.

Structure
REQ-034 A package foc_pkg SHALL hold the state enum, NUM_COEF=4, and coefficient index constants (KP=0, KI=1, KD=2, K3=3).
REQ-035 One sub-module, foc_sat_neg_sum, SHALL compute the saturated -(A+B).

Verification
REQ-036 Shadow d/q = {4096, 512, 0, 0}, then cfg_start -> four cycles of wen=0 with addr 0..3 and data 4096, 512, 0, 0 on both axes, then wen=1, then ARMED.
REQ-037 In ARMED, samp A=16384, B=-16384 -> currC_out=0, valid_out high exactly 4 cycles; ready pulse -> ARMED.
REQ-038 A=B=-262144 (min) -> currC_out=262143 (saturated).
REQ-039 Three samp_valid pulses during WAIT -> drop_cnt=2; after ready, the third sample launches one cycle after ARMED entry.
REQ-040 ready held low with TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles, then ARMED.
REQ-041 rst asserted at cycle 2 of CFG -> wen=1 and state IDLE in the same cycle; no further writes.
